// File: rtl/aes_encipher_core.sv
// Iterative AES-128 encipher datapath: one round per clock using an external S-box array.
// Rounds run on the 10 edges after acceptance. The result_valid pulse follows the last round.
module aes_encipher_core #(
  parameter int NR = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [127:0]  block_in,
  input  logic [127:0]  key,
  input  logic          key_ready,
  input  logic [1279:0] round_keys,
  output logic [127:0]  sboxw,
  input  logic [127:0]  new_sboxw,
  output logic          ready,
  output logic [127:0]  result,
  output logic          result_valid
);

  typedef enum logic [1:0] {IDLE, WAIT_KEY, ROUND} fsm_t;

  localparam logic [3:0] LAST = 4'(NR);

  fsm_t         fsm, fsm_next;
  logic [127:0] state;
  logic [3:0]   round;
  logic [3:0]   rk_idx;
  logic [127:0] rk, shifted, mixed, round_out;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] w);
    logic [7:0] b0, b1, b2, b3;
    b0 = w[31:24];
    b1 = w[23:16];
    b2 = w[15:8];
    b3 = w[7:0];
    return {xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3,
            b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3,
            b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3,
            xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3)};
  endfunction

  // Byte k of the block sits at [127-8k -: 8]; row = k%4, column = k/4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  assign ready = (fsm == IDLE);
  assign sboxw = (fsm == ROUND) ? state : 128'd0;

  always_comb begin
    mixed   = '0;
    shifted = shift_rows(new_sboxw);
    for (int c = 0; c < 4; c++) begin
      mixed[127-32*c -: 32] = mix_column(shifted[127-32*c -: 32]);
    end
    rk_idx    = (round == 4'd0) ? 4'd0 : round - 4'd1;
    rk        = round_keys[128*rk_idx +: 128];
    round_out = ((round == LAST) ? shifted : mixed) ^ rk;
  end

  always_comb begin
    fsm_next = fsm;
    case (fsm)
      IDLE:     if (start) fsm_next = key_ready ? ROUND : WAIT_KEY;
      WAIT_KEY: if (key_ready) fsm_next = ROUND;
      ROUND:    if (round == LAST) fsm_next = IDLE;
      default:  fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm <= IDLE;
    end else begin
      fsm <= fsm_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= '0;
      round        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start) begin
            state <= block_in ^ key;
            round <= 4'd1;
          end
        end
        ROUND: begin
          state <= round_out;
          if (round == LAST) begin
            result       <= round_out;
            result_valid <= 1'b1;
            round        <= 4'd0;
          end else begin
            round <= round + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_encipher_core.sv
// Bench for aes_encipher_core: FIPS-197 vectors, key_ready gating, busy rejection,
// back-to-back, mid-round reset and random blocks against a matrix-level AES model.
module tb_aes_encipher_core;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [127:0]  block_in;
  logic [127:0]  key;
  logic          key_ready;
  logic [1279:0] round_keys;
  logic [127:0]  sboxw;
  logic [127:0]  new_sboxw;
  logic          ready;
  logic [127:0]  result;
  logic          result_valid;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  logic [7:0] sbox [256];

  aes_encipher_core #(.NR(10)) dut (
    .clk(clk), .reset(reset), .start(start), .block_in(block_in), .key(key),
    .key_ready(key_ready), .round_keys(round_keys), .sboxw(sboxw),
    .new_sboxw(new_sboxw), .ready(ready), .result(result), .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  always_comb begin
    new_sboxw = '0;
    for (int i = 0; i < 16; i++) new_sboxw[8*i +: 8] = sbox[sboxw[8*i +: 8]];
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] get_byte(input logic [127:0] v, input int row, input int col);
    return v[127-8*(4*col+row) -: 8];
  endfunction

  function automatic logic [1279:0] expand(input logic [127:0] k);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1279:0] o;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 1; r <= 10; r++) o[128*(r-1) +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return o;
  endfunction

  // State held as a 4x4 byte matrix; MixColumns as a generic GF(2^8) matrix product.
  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] k);
    logic [1279:0] rks;
    logic [127:0]  rk, o;
    logic [7:0]    st [4][4];
    logic [7:0]    tmp [4][4];
    logic [7:0]    acc, coef;
    rks = expand(k);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) st[r][c] = get_byte(pt, r, c) ^ get_byte(k, r, c);
    for (int rnd = 1; rnd <= 10; rnd++) begin
      rk = rks[128*(rnd-1) +: 128];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) tmp[r][c] = sbox[st[r][(c+r)%4]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          if (rnd < 10) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) begin
              coef = ((j - r + 4) % 4 == 0) ? 8'h02 : ((j - r + 4) % 4 == 1) ? 8'h03 : 8'h01;
              acc = acc ^ gmul(coef, tmp[j][c]);
            end
          end else begin
            acc = tmp[r][c];
          end
          st[r][c] = acc ^ get_byte(rk, r, c);
        end
    end
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) o[127-8*(4*c+r) -: 8] = st[r][c];
    return o;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_enc(input logic [127:0] pt, input logic [127:0] k, input int kr_delay,
                         input bit busy, output int lat, output logic [127:0] r1);
    block_in   = pt;
    key        = k;
    round_keys = expand(k);
    key_ready  = (kr_delay == 0);
    start      = 1'b1;
    tick();
    start = 1'b0;
    lat   = 0;
    r1    = '0;
    chk("ready_low_after_accept", 128'(ready), 128'd0);
    chk("valid_clear_after_accept", 128'(result_valid), 128'd0);
    while (!result_valid && lat < 60) begin
      if (lat < kr_delay) chk("sboxw_zero_in_wait", sboxw, 128'd0);
      if (lat + 1 >= kr_delay) key_ready = 1'b1;
      if (busy && (lat == 3 || lat == 7)) begin
        start    = 1'b1;
        block_in = ~pt;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
      if (lat == kr_delay + 1) r1 = dut.state;
    end
    start    = 1'b0;
    block_in = pt;
  endtask

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  initial begin
    int           lat, lat2, pulses, d;
    logic [127:0] r1, pt, k;
    logic [7:0]   inv;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end

    reset = 1'b1; start = 1'b0; block_in = '0; key = '0; key_ready = 1'b0; round_keys = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("reset_ready", 128'(ready), 128'd1);
    chk("reset_result", result, 128'd0);
    chk("reset_valid", 128'(result_valid), 128'd0);
    chk("reset_sboxw", sboxw, 128'd0);

    // FIPS-197 C.1 with single-cycle pulse
    run_enc(C1_PT, C1_KEY, 0, 1'b0, lat, r1);
    chk("c1_latency", 128'(lat), 128'd10);
    chk("c1_result", result, C1_CT);
    chk("c1_ready_back", 128'(ready), 128'd1);
    tick();
    chk("c1_pulse_one_cycle", 128'(result_valid), 128'd0);
    chk("c1_result_held", result, C1_CT);

    // FIPS-197 Appendix B, including state after round 1
    run_enc(B_PT, B_KEY, 0, 1'b0, lat, r1);
    chk("b_round1_state", r1, 128'ha49c7ff2689f352b6b5bea43026a5049);
    chk("b_latency", 128'(lat), 128'd10);
    chk("b_result", result, B_CT);
    tick();

    // key_ready raised 5 cycles late
    run_enc(C1_PT, C1_KEY, 5, 1'b0, lat, r1);
    chk("keywait_latency", 128'(lat), 128'd15);
    chk("keywait_result", result, C1_CT);
    tick();

    // busy starts ignored, then back-to-back on first ready cycle
    run_enc(C1_PT, C1_KEY, 0, 1'b1, lat, r1);
    chk("busy_latency", 128'(lat), 128'd10);
    chk("busy_result", result, C1_CT);
    run_enc(B_PT, B_KEY, 0, 1'b0, lat2, r1);
    chk("b2b_gap", 128'(lat2 + 1), 128'd11);
    chk("b2b_result", result, B_CT);
    tick();

    // reset in round 5: state changes immediately, nothing completes afterwards
    block_in = C1_PT; key = C1_KEY; round_keys = expand(C1_KEY); key_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("pre_reset_busy", 128'(ready), 128'd0);
    reset = 1'b1;
    #1;
    chk("midreset_ready", 128'(ready), 128'd1);
    chk("midreset_result", result, 128'd0);
    chk("midreset_valid", 128'(result_valid), 128'd0);
    tick();
    reset  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (result_valid) pulses++;
    end
    chk("midreset_no_pulse", 128'(pulses), 128'd0);
    run_enc(C1_PT, C1_KEY, 0, 1'b0, lat, r1);
    chk("post_reset_latency", 128'(lat), 128'd10);
    chk("post_reset_result", result, C1_CT);
    tick();

    // random blocks and keys with random key_ready delays
    for (int i = 0; i < 6; i++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      k  = {$urandom, $urandom, $urandom, $urandom};
      d  = int'($urandom_range(0, 3));
      run_enc(pt, k, d, 1'b0, lat, r1);
      chk("rand_latency", 128'(lat), 128'(10 + d));
      chk("rand_result", result, ref_encrypt(pt, k));
      tick();
    end

    if (n_pass + n_fail != n_total) $display("check count inconsistent");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
